// File: rtl/legv8_imm_gen_pipe.sv
// LEGv8 immediate generator: decode, extract, extend and shift the
// immediate field behind a 2-stage valid/ready pipeline.
module legv8_imm_gen_pipe #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] imm_out,
    output logic [2:0]        fmt_out,
    output logic              illegal_out,
    output logic [CNT_W-1:0]  illegal_cnt
);

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_D    = 3'd1,
        FMT_I    = 3'd2,
        FMT_B    = 3'd3,
        FMT_CB   = 3'd4,
        FMT_IW   = 3'd5
    } fmt_e;

    typedef struct packed {
        logic [31:0] instr;
        fmt_e        fmt;
    } s1_t;

    logic              s1_valid;
    logic              s2_valid;
    logic              s1_load;
    logic              s2_load;
    s1_t               s1_q;
    fmt_e              fmt_d;
    logic [DATA_W-1:0] imm_d;
    logic [DATA_W-1:0] iw_base;
    logic              unused_bits;

    assign s2_load   = !s2_valid || out_ready;
    assign s1_load   = !s1_valid || s2_load;
    assign in_ready  = s1_load;
    assign out_valid = s2_valid;

    assign unused_bits = ^{s1_q.instr[31:26], s1_q.instr[4:0]};

    // Opcode classes are mutually exclusive, so order does not matter here
    always_comb begin
        fmt_d = FMT_NONE;
        unique case (1'b1)
            instr[31:26] == 6'b000101 ||
            instr[31:26] == 6'b100101:
                fmt_d = FMT_B;
            instr[31:24] == 8'b10110100 ||
            instr[31:24] == 8'b10110101 ||
            instr[31:24] == 8'b01010100:
                fmt_d = FMT_CB;
            instr[31:23] == 9'b110100101 ||
            instr[31:23] == 9'b111100101:
                fmt_d = FMT_IW;
            instr[31] &&
            (instr[28:22] == 7'b1000100 ||
             instr[28:22] == 7'b1001000):
                fmt_d = FMT_I;
            instr[31:21] == 11'b11111000000 ||
            instr[31:21] == 11'b11111000010:
                fmt_d = FMT_D;
            default:
                fmt_d = FMT_NONE;
        endcase
        // A 32-bit result cannot hold hw=2/3 wide moves
        if (DATA_W == 32 && fmt_d == FMT_IW && instr[22])
            fmt_d = FMT_NONE;
    end

    assign iw_base = {{(DATA_W-16){1'b0}}, s1_q.instr[20:5]};

    always_comb begin
        imm_d = '0;
        unique case (s1_q.fmt)
            FMT_D:
                imm_d = {{(DATA_W-9){s1_q.instr[20]}},
                         s1_q.instr[20:12]};
            FMT_I:
                imm_d = {{(DATA_W-12){1'b0}},
                         s1_q.instr[21:10]};
            FMT_B:
                imm_d = {{(DATA_W-28){s1_q.instr[25]}},
                         s1_q.instr[25:0], 2'b00};
            FMT_CB:
                imm_d = {{(DATA_W-21){s1_q.instr[23]}},
                         s1_q.instr[23:5], 2'b00};
            FMT_IW:
                imm_d = iw_base << {s1_q.instr[22:21], 4'b0000};
            default:
                imm_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s1_q        <= '0;
            s2_valid    <= 1'b0;
            imm_out     <= '0;
            fmt_out     <= '0;
            illegal_out <= 1'b0;
            illegal_cnt <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_q.instr <= instr;
                    s1_q.fmt   <= fmt_d;
                end
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    imm_out     <= imm_d;
                    fmt_out     <= s1_q.fmt;
                    illegal_out <= (s1_q.fmt == FMT_NONE);
                end
            end
            if (s2_valid && out_ready && illegal_out &&
                illegal_cnt != '1)
                illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_legv8_imm_gen_pipe.sv
// Bench for legv8_imm_gen_pipe: 64- and 32-bit instances side by side,
// fixed vectors, random traffic against a reference model, corner sequences.
module tb_legv8_imm_gen_pipe;

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } res_t;

    typedef struct packed {
        logic [31:0] ins;
        res_t        e64;
        res_t        e32;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instr = '0;

    logic        in_ready64, out_valid64, ill64;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic [7:0]  cnt64;

    logic        in_ready32, out_valid32, ill32;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic [7:0]  cnt32;

    int   nvec = 0;
    int   nerr = 0;
    res_t q64[$];
    res_t q32[$];
    int   mcnt64 = 0;
    int   mcnt32 = 0;

    always #5 clk = ~clk;

    legv8_imm_gen_pipe #(.DATA_W(64), .CNT_W(8)) dut64 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready64), .instr(instr),
        .out_valid(out_valid64), .out_ready(out_ready),
        .imm_out(imm64), .fmt_out(fmt64),
        .illegal_out(ill64), .illegal_cnt(cnt64)
    );

    legv8_imm_gen_pipe #(.DATA_W(32), .CNT_W(8)) dut32 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready32), .instr(instr),
        .out_valid(out_valid32), .out_ready(out_ready),
        .imm_out(imm32), .fmt_out(fmt32),
        .illegal_out(ill32), .illegal_cnt(cnt32)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic longint sext(input longint x, input int n);
        if (((x >> (n - 1)) & 1) != 0)
            return x - (longint'(1) << n);
        return x;
    endfunction

    // Reference: classify by opcode lists, compute value as an integer
    function automatic res_t ref_res(input logic [31:0] i, input int w);
        res_t        r;
        longint      v;
        int          hw;
        logic [5:0]  o6;
        logic [7:0]  o8;
        logic [8:0]  o9;
        logic [9:0]  o10;
        logic [10:0] o11;
        o6 = i[31:26];
        o8 = i[31:24];
        o9 = i[31:23];
        o10 = i[31:22];
        o11 = i[31:21];
        v = 0;
        r.fmt = 3'd0;
        if (o6 inside {6'b000101, 6'b100101}) begin
            r.fmt = 3'd3;
            v = sext(longint'(i[25:0]), 26) * 4;
        end else if (o8 inside {8'hB4, 8'hB5, 8'h54}) begin
            r.fmt = 3'd4;
            v = sext(longint'(i[23:5]), 19) * 4;
        end else if (o9 inside {9'b110100101, 9'b111100101}) begin
            hw = int'(i[22:21]);
            if (!(w == 32 && hw >= 2)) begin
                r.fmt = 3'd5;
                v = longint'(i[20:5]) * (longint'(1) << (16 * hw));
            end
        end else if (o10 inside {10'b1001000100, 10'b1011000100,
                                 10'b1101000100, 10'b1111000100,
                                 10'b1001001000, 10'b1011001000,
                                 10'b1101001000, 10'b1111001000}) begin
            r.fmt = 3'd2;
            v = longint'(i[21:10]);
        end else if (o11 inside {11'b11111000000, 11'b11111000010}) begin
            r.fmt = 3'd1;
            v = sext(longint'(i[20:12]), 9);
        end
        r.ill = (r.fmt == 3'd0);
        r.imm = v;
        if (w == 32)
            r.imm[63:32] = '0;
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 6))
            0: r[31:26] = $urandom_range(0, 1) ? 6'b100101 : 6'b000101;
            1: case ($urandom_range(0, 2))
                   0: r[31:24] = 8'hB4;
                   1: r[31:24] = 8'hB5;
                   default: r[31:24] = 8'h54;
               endcase
            2: r[31:23] = $urandom_range(0, 1) ? 9'b110100101 : 9'b111100101;
            3: r[31:22] = {1'b1, 2'($urandom_range(0, 3)),
                           ($urandom_range(0, 1) ? 7'b1000100 : 7'b1001000)};
            4: r[31:21] = $urandom_range(0, 1) ? 11'b11111000000
                                               : 11'b11111000010;
            default: ;
        endcase
        return r;
    endfunction

    function automatic vec_t mk(input logic [31:0] i,
                                input logic [63:0] m64, input logic [2:0] f64,
                                input logic [31:0] m32, input logic [2:0] f32);
        vec_t t;
        t.ins = i;
        t.e64.imm = m64;
        t.e64.fmt = f64;
        t.e64.ill = (f64 == 3'd0);
        t.e32.imm = {32'h0, m32};
        t.e32.fmt = f32;
        t.e32.ill = (f32 == 3'd0);
        return t;
    endfunction

    task automatic cycle(input logic v, input logic [31:0] ins,
                         input logic rdy, input res_t e64, input res_t e32,
                         output logic acc);
        in_valid = v;
        instr = ins;
        out_ready = rdy;
        @(negedge clk);
        chk("in_ready64", in_ready64, (q64.size() < 2) || rdy);
        chk("in_ready32", in_ready32, (q32.size() < 2) || rdy);
        chk("cnt64", cnt64, mcnt64);
        chk("cnt32", cnt32, mcnt32);
        if (q64.size() == 0) begin
            chk("spurious64", out_valid64, 1'b0);
        end else if (out_valid64) begin
            chk("imm64", imm64, q64[0].imm);
            chk("fmt64", fmt64, q64[0].fmt);
            chk("ill64", ill64, q64[0].ill);
            if (rdy) begin
                if (q64[0].ill && mcnt64 < 255) mcnt64++;
                void'(q64.pop_front());
            end
        end
        if (q32.size() == 0) begin
            chk("spurious32", out_valid32, 1'b0);
        end else if (out_valid32) begin
            chk("imm32", imm32, q32[0].imm);
            chk("fmt32", fmt32, q32[0].fmt);
            chk("ill32", ill32, q32[0].ill);
            if (rdy) begin
                if (q32[0].ill && mcnt32 < 255) mcnt32++;
                void'(q32.pop_front());
            end
        end
        acc = v && in_ready64;
        if (acc) q64.push_back(e64);
        if (v && in_ready32) q32.push_back(e32);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        logic a;
        int   n;
        res_t z;
        z = '0;
        n = 0;
        while ((q64.size() != 0 || q32.size() != 0) && n < 10) begin
            cycle(1'b0, 32'h0, 1'b1, z, z, a);
            n++;
        end
        chk("drain_left", q64.size() + q32.size(), 0);
        repeat (2) cycle(1'b0, 32'h0, 1'b1, z, z, a);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[$];
        vec_t        t;
        res_t        z;
        logic        a;
        int          idx;
        logic [31:0] x;
        logic [31:0] bp[4];
        z = '0;

        tbl.push_back(mk(32'hF85F8041, 64'hFFFFFFFFFFFFFFF8, 3'd1, 32'hFFFFFFF8, 3'd1));
        tbl.push_back(mk(32'h913FFC00, 64'h0000000000000FFF, 3'd2, 32'h00000FFF, 3'd2));
        tbl.push_back(mk(32'h17FFFFFF, 64'hFFFFFFFFFFFFFFFC, 3'd3, 32'hFFFFFFFC, 3'd3));
        tbl.push_back(mk(32'hB4FFFFE0, 64'hFFFFFFFFFFFFFFFC, 3'd4, 32'hFFFFFFFC, 3'd4));
        tbl.push_back(mk(32'hD2E24680, 64'h1234000000000000, 3'd5, 32'h00000000, 3'd0));
        tbl.push_back(mk(32'h00000000, 64'h0000000000000000, 3'd0, 32'h00000000, 3'd0));
        tbl.push_back(mk(32'hD2B579A0, 64'h00000000ABCD0000, 3'd5, 32'hABCD0000, 3'd5));
        tbl.push_back(mk(32'h15FFFFFF, 64'h0000000007FFFFFC, 3'd3, 32'h07FFFFFC, 3'd3));
        tbl.push_back(mk(32'h96000000, 64'hFFFFFFFFF8000000, 3'd3, 32'hF8000000, 3'd3));
        tbl.push_back(mk(32'h54800000, 64'hFFFFFFFFFFF00000, 3'd4, 32'hFFF00000, 3'd4));
        tbl.push_back(mk(32'hF80FF000, 64'h00000000000000FF, 3'd1, 32'h000000FF, 3'd1));
        tbl.push_back(mk(32'hD1200000, 64'h0000000000000800, 3'd2, 32'h00000800, 3'd2));
        tbl.push_back(mk(32'hF8200000, 64'h0000000000000000, 3'd0, 32'h00000000, 3'd0));
        tbl.push_back(mk(32'hD2C00020, 64'h0000000100000000, 3'd5, 32'h00000000, 3'd0));

        #12;
        chk("rst_out_valid64", out_valid64, 1'b0);
        chk("rst_imm64", imm64, 64'h0);
        chk("rst_fmt64", fmt64, 3'd0);
        chk("rst_ill64", ill64, 1'b0);
        chk("rst_cnt64", cnt64, 8'd0);
        chk("rst_out_valid32", out_valid32, 1'b0);
        chk("rst_imm32", imm32, 32'h0);
        chk("rst_cnt32", cnt32, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        foreach (tbl[k]) begin
            t = tbl[k];
            cycle(1'b1, t.ins, 1'b1, t.e64, t.e32, a);
            drain();
        end

        foreach (tbl[k]) begin
            t = tbl[k];
            cycle(1'b1, t.ins, 1'b1, t.e64, t.e32, a);
        end
        drain();

        for (int c = 0; c < 600; c++) begin
            x = rand_instr();
            cycle(logic'($urandom_range(0, 3) != 0), x,
                  logic'($urandom_range(0, 3) != 0),
                  ref_res(x, 64), ref_res(x, 32), a);
        end
        drain();

        bp[0] = 32'hF85F8041;
        bp[1] = 32'h913FFC00;
        bp[2] = 32'h17FFFFFF;
        bp[3] = 32'hD2E24680;
        idx = 0;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            cycle(1'b1, bp[idx], logic'(c >= 5),
                  ref_res(bp[idx], 64), ref_res(bp[idx], 32), a);
            if (a) idx++;
            if (c == 4) chk("bp_accepts_stalled", idx, 2);
        end
        chk("bp_all_accepted", idx, 4);
        drain();

        cycle(1'b1, 32'h0, 1'b0, ref_res(32'h0, 64), ref_res(32'h0, 32), a);
        cycle(1'b1, 32'hF85F8041, 1'b0,
              ref_res(32'hF85F8041, 64), ref_res(32'hF85F8041, 32), a);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_out_valid64", out_valid64, 1'b0);
        chk("midrst_out_valid32", out_valid32, 1'b0);
        chk("midrst_cnt64", cnt64, 8'd0);
        chk("midrst_cnt32", cnt32, 8'd0);
        q64.delete();
        q32.delete();
        mcnt64 = 0;
        mcnt32 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        repeat (4) cycle(1'b0, 32'h0, 1'b1, z, z, a);

        for (int c = 0; c < 300; c++)
            cycle(1'b1, 32'h0, 1'b1, ref_res(32'h0, 64), ref_res(32'h0, 32), a);
        drain();
        chk("cnt_sat64", cnt64, 8'd255);
        chk("cnt_sat32", cnt32, 8'd255);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
